led_fader: RTL and testbench
============================

Name: led_fader

Overview:
Downstream stage of the free-running counter LED driver. It consumes the 4-bit on/off LED pattern the counter produces and turns each hard edge into a linear brightness ramp. Each channel has its own brightness level, which steps toward full-on or full-off once per step tick. One shared PWM counter converts all levels to pin drive. It sits between the counter block's LED bits and the board LED pins.

Parameters:
PWM_BITS, 8, width of the brightness level and PWM counter; MAX = 2**PWM_BITS-1
STEP_DIV, 65536, clocks per brightness step; legal range >=2
CH, 4, number of LED channels

Ports:
i_clk  input  1  system clock, all logic on rising edge
i_rst_n  input  1  asynchronous active-low reset
i_en  input  1  fader enable; low forces all channels dark
i_led  input  CH  target pattern (1 = fade to full, 0 = fade to off), same clock domain
o_led  output  CH  registered PWM drive to LED pins
o_busy  output  1  registered; high while any channel is RISING or FALLING

Behaviour:
- Reset (i_rst_n low, asynchronous): pwm_cnt=0, div_cnt=0, every level=0, every channel state=OFF, o_led=0, o_busy=0.
- PWM counter:
  - Counts 0..MAX-1, then wraps to 0, giving a period of MAX clocks.
  - Advances every cycle while i_en=1.
- Step divider:
  - Counts 0..STEP_DIV-1 and wraps.
  - tick=1 during the cycle in which div_cnt==STEP_DIV-1.
- Channel FSM (per channel k), evaluated every clock:
  - OFF (level=0): i_led[k]=1 -> RISING.
  - RISING: on tick, level+1. Reaching MAX -> ON. i_led[k]=0 -> FALLING immediately, level held.
  - ON (level=MAX): i_led[k]=0 -> FALLING.
  - FALLING: on tick, level-1. Reaching 0 -> OFF. i_led[k]=1 -> RISING immediately, level held.
  - Level saturates: never wraps above MAX or below 0.
- Transition timing:
  - A state transition and a tick in the same cycle: the new state takes effect next cycle; the step in that cycle follows the old state.
  - Glitch shorter than one tick: state toggles, level unchanged.
  - A full ramp takes MAX ticks = MAX*STEP_DIV clocks, plus up to STEP_DIV-1 clocks of tick phase.
- Output:
  - o_led[k] <= (level[k] > pwm_cnt). Registered, so 1 clock of latency from level/pwm_cnt to pin.
  - level=0 gives constant 0; level=MAX gives constant 1.
  - Duty = level/MAX.
- o_busy: registered OR over channels of (state==RISING or state==FALLING).
- i_en=0, synchronous, highest priority:
  - Next edge: pwm_cnt=0, div_cnt=0, all levels=0, all states=OFF.
  - o_led=0 and o_busy=0 one cycle later.
  - i_led is ignored while i_en=0.
  - When i_en returns to 1, ramps restart from 0 and the first tick comes STEP_DIV clocks later.
- Reset mid-ramp: immediate return to reset values; no partial state survives.
- Channels are fully independent. Only pwm_cnt and tick are shared.

Test Plan:
(Bench parameters: PWM_BITS=4, so MAX=15; STEP_DIV=4; CH=4.)
1. Reset, i_en=1, i_led=0000, run 200 clocks -> o_led=0000 constant, o_busy=0.
2. i_led=0001 held -> o_busy rises within 2 clocks. level[0] reaches 15 after 60 +/-3 clocks, then o_led[0]=1 constant and o_busy=0. Mid-ramp at level=5, o_led[0] is high 5 of every 15 clocks.
3. From ON, i_led=0000 -> o_led[0] high-time per 15-clock period decreases by 1 every 4 clocks. After 60 +/-3 clocks, o_led[0]=0 constant.
4. Mid-rise at level=7, drop i_led[0] for 2 clocks then restore -> level stays 7 (+/-1), and the ramp resumes to 15 with no wrap to 0.
5. Channels 0 and 2 ON, pulse i_en=0 for 1 clock -> the next o_led sample is 0000 and o_busy=0. With i_led still 0101, both channels ramp again from 0, and the first increment occurs 4 clocks after i_en returns high.
6. Assert i_rst_n=0 asynchronously mid-ramp (between clock edges) -> o_led=0000 and o_busy=0 without waiting for a clock edge. After release, all channels start from level 0.

Source files
------------

// File: rtl/led_fader.sv
// led_fader: turns a CH-bit on/off LED pattern into per-channel linear brightness ramps.
// Latency: o_led is registered, 1 clock after level/pwm_cnt; o_busy 1 clock after channel state.
// Backpressure: none; i_led is sampled every clock, and i_en=0 clears all state on the next edge.
//
// Ports:
//   i_clk    system clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   i_en     fader enable; low forces every channel dark and restarts the counters
//   i_led    per-channel target (1 = fade to full, 0 = fade to off)
//   o_led    registered PWM drive, duty = level/MAX
//   o_busy   registered; high while any channel is ramping
module led_fader #(
  parameter int unsigned PWM_BITS = 8,
  parameter int unsigned STEP_DIV = 65536,
  parameter int unsigned CH       = 4
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_en,
  input  logic [CH-1:0] i_led,
  output logic [CH-1:0] o_led,
  output logic          o_busy
);

  localparam logic [PWM_BITS-1:0] MAX      = '1;
  localparam logic [PWM_BITS-1:0] PWM_LAST = MAX - 1'b1;
  localparam int unsigned         DIV_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(STEP_DIV - 1);

  typedef enum logic [1:0] {
    ST_OFF     = 2'd0,
    ST_RISING  = 2'd1,
    ST_ON      = 2'd2,
    ST_FALLING = 2'd3
  } state_e;

  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic [PWM_BITS-1:0] level_q [CH];
  logic [PWM_BITS-1:0] level_d [CH];
  state_e              state_q [CH];
  state_e              state_d [CH];
  logic [CH-1:0]       led_q, led_d;
  logic                busy_q, busy_d;
  logic                tick;

  // Shared timebase: PWM period of MAX clocks and a step tick every STEP_DIV clocks.
  always_comb begin
    pwm_cnt_d = (pwm_cnt_q == PWM_LAST) ? '0 : pwm_cnt_q + 1'b1;
    div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + 1'b1;
    if (!i_en) begin
      pwm_cnt_d = '0;
      div_cnt_d = '0;
    end
  end

  assign tick = (div_cnt_q == DIV_LAST);

  // Per-channel ramp FSM. The level step in a cycle always follows the current
  // state; a direction change requested in the same cycle only redirects later
  // steps. Entering RISING/FALLING with the level already at the bound (a short
  // glitch seen from ON/OFF) settles back on the next cycle without stepping.
  always_comb begin
    busy_d = 1'b0;
    led_d  = '0;
    for (int k = 0; k < int'(CH); k++) begin
      level_d[k] = level_q[k];
      state_d[k] = state_q[k];
      led_d[k]   = (level_q[k] > pwm_cnt_q);

      if (state_q[k] == ST_RISING || state_q[k] == ST_FALLING) begin
        busy_d = 1'b1;
      end

      case (state_q[k])
        ST_OFF: begin
          if (i_led[k]) state_d[k] = ST_RISING;
        end
        ST_RISING: begin
          if (tick && level_q[k] != MAX) level_d[k] = level_q[k] + 1'b1;
          if (!i_led[k])               state_d[k] = ST_FALLING;
          else if (level_d[k] == MAX)  state_d[k] = ST_ON;
        end
        ST_ON: begin
          if (!i_led[k]) state_d[k] = ST_FALLING;
        end
        ST_FALLING: begin
          if (tick && level_q[k] != '0) level_d[k] = level_q[k] - 1'b1;
          if (i_led[k])                state_d[k] = ST_RISING;
          else if (level_d[k] == '0)   state_d[k] = ST_OFF;
        end
        default: state_d[k] = ST_OFF;
      endcase

      if (!i_en) begin
        level_d[k] = '0;
        state_d[k] = ST_OFF;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pwm_cnt_q <= '0;
      div_cnt_q <= '0;
      led_q     <= '0;
      busy_q    <= 1'b0;
      for (int k = 0; k < int'(CH); k++) begin
        level_q[k] <= '0;
        state_q[k] <= ST_OFF;
      end
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
      div_cnt_q <= div_cnt_d;
      led_q     <= led_d;
      busy_q    <= busy_d;
      for (int k = 0; k < int'(CH); k++) begin
        level_q[k] <= level_d[k];
        state_q[k] <= state_d[k];
      end
    end
  end

  assign o_led  = led_q;
  assign o_busy = busy_q;

endmodule

// File: tb/tb_led_fader.sv
// tb_led_fader: random and directed stimulus for led_fader checked each clock against a reference model.
// Latency: outputs compared 1 time unit after every rising edge.
// Backpressure: none.
module tb_led_fader;

  localparam int MAXV = 15;
  localparam int SD   = 4;
  localparam int NCH  = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [3:0] led_in;
  logic [3:0] o_led;
  logic       o_busy;

  int total = 0;
  int bad   = 0;

  // Reference model: cyc counts enabled clocks since the last clear, so the
  // PWM phase and tick fall out of modulo arithmetic. Each channel keeps a
  // latched target direction and a level that drifts one step toward it on
  // every tick, clamped to [0, MAXV]. A channel is settled once its latched
  // target agrees with i_led and its level sits at that target's end.
  int         m_cyc;
  int         m_lvl     [NCH];
  bit         m_tgt     [NCH];
  bit         m_settled [NCH];
  logic [3:0] exp_led;
  logic       exp_busy;

  led_fader #(
    .PWM_BITS (4),
    .STEP_DIV (SD),
    .CH       (NCH)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_en    (en),
    .i_led   (led_in),
    .o_led   (o_led),
    .o_busy  (o_busy)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_cyc = 0;
    for (int k = 0; k < NCH; k++) begin
      m_lvl[k]     = 0;
      m_tgt[k]     = 1'b0;
      m_settled[k] = 1'b1;
    end
    exp_led  = 4'b0000;
    exp_busy = 1'b0;
  endfunction

  // Advance the model across one rising edge using the inputs held at that edge.
  function automatic void model_edge();
    int pwm;
    bit tick;
    pwm      = m_cyc % MAXV;
    tick     = ((m_cyc % SD) == SD - 1);
    exp_busy = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      exp_led[k] = (m_lvl[k] > pwm);
      if (!m_settled[k]) exp_busy = 1'b1;
    end
    if (!en) begin
      m_cyc = 0;
      for (int k = 0; k < NCH; k++) begin
        m_lvl[k]     = 0;
        m_tgt[k]     = 1'b0;
        m_settled[k] = 1'b1;
      end
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (tick) begin
          if (m_tgt[k]) m_lvl[k] = (m_lvl[k] < MAXV) ? m_lvl[k] + 1 : MAXV;
          else          m_lvl[k] = (m_lvl[k] > 0)    ? m_lvl[k] - 1 : 0;
        end
        m_settled[k] = (m_tgt[k] == led_in[k]) && (m_lvl[k] == (led_in[k] ? MAXV : 0));
        m_tgt[k]     = led_in[k];
      end
      m_cyc++;
    end
  endfunction

  task automatic check_outputs(input string tag);
    total++;
    assert (o_led === exp_led) else begin
      bad++;
      $error("FAIL %s o_led: got %b want %b", tag, o_led, exp_led);
    end
    total++;
    assert (o_busy === exp_busy) else begin
      bad++;
      $error("FAIL %s o_busy: got %b want %b", tag, o_busy, exp_busy);
    end
  endtask

  task automatic run(input int n, input string tag);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      #1;
      check_outputs(tag);
    end
  endtask

  initial begin
    int  busy_cnt;
    bit  done;

    // Reset state
    rst_n  = 1'b0;
    en     = 1'b0;
    led_in = 4'b0000;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    rst_n = 1'b1;
    en    = 1'b1;

    // Idle: nothing lights
    run(200, "idle");

    // Full rise on channel 0, timing of the busy window
    led_in   = 4'b0001;
    busy_cnt = 0;
    done     = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      run(1, "rise0");
      if (o_busy) busy_cnt++;
      else if (busy_cnt > 0) done = 1'b1;
    end
    total++;
    assert (busy_cnt >= 56 && busy_cnt <= 63) else begin
      bad++;
      $error("FAIL rise_time busy cycles: got %0d want 56..63", busy_cnt);
    end
    run(30, "on0");

    // Full fall back to dark
    led_in = 4'b0000;
    run(90, "fall0");

    // Glitch mid-rise: level must hold, then continue to full
    led_in = 4'b0001;
    run(30, "rise_pre_glitch");
    led_in = 4'b0000;
    run(2, "glitch");
    led_in = 4'b0001;
    run(80, "rise_post_glitch");

    // One-clock enable pulse with channels 0 and 2 lit
    led_in = 4'b0101;
    run(80, "ch02_on");
    en = 1'b0;
    run(1, "en_low");
    en = 1'b1;
    run(1, "en_back");
    total++;
    assert (o_led === 4'b0000) else begin
      bad++;
      $error("FAIL en_pulse o_led: got %b want 0000", o_led);
    end
    total++;
    assert (o_busy === 1'b0) else begin
      bad++;
      $error("FAIL en_pulse o_busy: got %b want 0", o_busy);
    end
    run(80, "ch02_reramp");

    // Asynchronous reset between edges, mid-ramp
    led_in = 4'b0000;
    run(80, "dark_again");
    led_in = 4'b1111;
    run(22, "ramp_all");
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    assert (o_led === 4'b0000) else begin
      bad++;
      $error("FAIL async_rst o_led: got %b want 0000", o_led);
    end
    total++;
    assert (o_busy === 1'b0) else begin
      bad++;
      $error("FAIL async_rst o_busy: got %b want 0", o_busy);
    end
    model_reset();
    @(posedge clk);
    #1;
    check_outputs("in_reset");
    rst_n = 1'b1;
    run(90, "after_reset");

    // Random patterns, hold lengths and enable drops
    repeat (40) begin
      led_in = 4'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        en = 1'b0;
        run($urandom_range(1, 3), "rand_en_low");
        en = 1'b1;
      end
      run($urandom_range(1, 80), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
